// File: rtl/spiker_stream_pkg.sv
// spiker_stream_pkg: shared FSM states and frame geometry helpers for the spike stream adapter
package spiker_stream_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int n_words(int n_spikes, int width);
    return (n_spikes + width - 1) / width;
  endfunction
  function automatic int n_beats(int n_spikes, int beat_w);
    return (n_spikes + beat_w - 1) / beat_w;
  endfunction
  function automatic logic spike_live(int pos, int n_spikes);
    return pos < n_spikes;
  endfunction
endpackage

// File: rtl/spiker_beat_packer.sv
// spiker_beat_packer: selects beat idx of a frame and zeroes positions past the last spike
module spiker_beat_packer import spiker_stream_pkg::*; #(
  parameter int TOT = 800,
  parameter int N_SPIKES = 784,
  parameter int BEAT_W = 16,
  parameter int CW = 6
) (
  input  logic [TOT-1:0]    frame,
  input  logic [CW-1:0]     idx,
  output logic [BEAT_W-1:0] beat
);
  logic [BEAT_W-1:0] live;
  for (genvar i = 0; i < BEAT_W; i++) begin : g_live
    assign live[i] = spike_live(int'(idx) * BEAT_W + i, N_SPIKES);
  end
  assign beat = BEAT_W'(frame >> (int'(idx) * BEAT_W)) & live;
endmodule

// File: rtl/spiker_stream_adapter.sv
// spiker_stream_adapter: streams a spike frame to the core in beats and reassembles result beats; SPIKER_STREAM_POPCNT_EN adds spike_count_o
module spiker_stream_adapter import spiker_stream_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int N_SPIKES = 784,
  parameter int BEAT_W = 16,
  localparam int N_WORDS = n_words(N_SPIKES, WIDTH),
  localparam int N_BEATS = n_beats(N_SPIKES, BEAT_W),
  localparam int CNTW = $clog2(N_SPIKES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [N_WORDS*WIDTH-1:0] spikes_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic [BEAT_W-1:0]        tx_data_o,
  output logic                     tx_last_o,
  input  logic                     rx_valid_i,
  output logic                     rx_ready_o,
  input  logic [BEAT_W-1:0]        rx_data_i,
  output logic [N_WORDS*WIDTH-1:0] result_o,
  output logic                     result_valid_o
`ifdef SPIKER_STREAM_POPCNT_EN
  ,
  output logic [CNTW-1:0]          spike_count_o
`endif
);
  localparam int TOT = N_WORDS * WIDTH;
  localparam int CW = $clog2(N_BEATS + 1);
  localparam logic [CW-1:0] FULL = CW'(N_BEATS);
  localparam logic [CW-1:0] LAST = CW'(N_BEATS - 1);
  localparam logic [TOT-1:0] FMASK = {TOT{1'b1}} >> (TOT - N_SPIKES);
  state_e state, state_n;
  logic [TOT-1:0] frame;
  logic [CW-1:0] tx_cnt, rx_cnt, tx_cnt_n, rx_cnt_n;
  logic [BEAT_W-1:0] rx_mask;
  logic tx_fire, rx_fire, start_ok;
  spiker_beat_packer #(.TOT(TOT), .N_SPIKES(N_SPIKES), .BEAT_W(BEAT_W), .CW(CW)) u_tx_pack (
    .frame(frame), .idx(tx_cnt), .beat(tx_data_o)
  );
  // packing an all-live frame yields the write-enable mask for the incoming result beat
  spiker_beat_packer #(.TOT(TOT), .N_SPIKES(N_SPIKES), .BEAT_W(BEAT_W), .CW(CW)) u_rx_pack (
    .frame(FMASK), .idx(rx_cnt), .beat(rx_mask)
  );
  // handshakes, status and next state; DONE waits for both directions to finish
  always_comb begin
    tx_valid_o = state == RUN && tx_cnt < FULL;
    rx_ready_o = state == RUN && rx_cnt < FULL;
    tx_last_o = tx_valid_o && tx_cnt == LAST;
    busy_o = state == RUN;
    done_o = state == DONE;
    tx_fire = tx_valid_o && tx_ready_i;
    rx_fire = rx_valid_i && rx_ready_o;
    tx_cnt_n = tx_cnt + CW'(tx_fire);
    rx_cnt_n = rx_cnt + CW'(rx_fire);
    start_ok = state == IDLE && start_i;
    state_n = state == IDLE ? (start_i ? RUN : IDLE)
            : state == RUN ? (tx_cnt_n == FULL && rx_cnt_n == FULL ? DONE : RUN)
            : IDLE;
  end
  // state register
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  // frame snapshot, beat counters and result assembly
  always_ff @(posedge clk_i)
    if (rst_i) begin
      frame <= '0;
      result_o <= '0;
      result_valid_o <= 1'b0;
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else if (start_ok) begin
      frame <= spikes_i & FMASK;
      result_o <= '0;
      result_valid_o <= 1'b0;
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      tx_cnt <= done_o ? '0 : tx_cnt_n;
      rx_cnt <= done_o ? '0 : rx_cnt_n;
      if (rx_fire) result_o <= result_o | (TOT'(rx_data_i & rx_mask) << (int'(rx_cnt) * BEAT_W));
      if (state_n == DONE) result_valid_o <= 1'b1;
    end
`ifdef SPIKER_STREAM_POPCNT_EN
  // running popcount of every accepted spike beat
  always_ff @(posedge clk_i)
    if (rst_i || start_ok) spike_count_o <= '0;
    else if (tx_fire) spike_count_o <= spike_count_o + CNTW'($countones(tx_data_o));
`endif
endmodule

// File: tb/tb_spiker_stream_adapter.sv
// tb_spiker_stream_adapter: randomized frames against a bit-level reference of the spike stream adapter
module tb_spiker_stream_adapter;
  localparam int WIDTH = 32;
  localparam int N_SPIKES = 784;
  localparam int BEAT_W = 16;
  localparam int N_WORDS = (N_SPIKES + WIDTH - 1) / WIDTH;
  localparam int N_BEATS = (N_SPIKES + BEAT_W - 1) / BEAT_W;
  localparam int TOT = N_WORDS * WIDTH;
  logic clk = 0;
  logic rst_i = 1, start_i = 0, tx_ready_i = 0, rx_valid_r = 0;
  logic [TOT-1:0] spikes_i = '0;
  logic [BEAT_W-1:0] rx_data_r = '0;
  logic busy_o, done_o, tx_valid_o, tx_last_o, rx_ready_o, result_valid_o, rx_valid_i;
  logic [BEAT_W-1:0] tx_data_o, rx_data_i;
  logic [TOT-1:0] result_o;
`ifdef SPIKER_STREAM_POPCNT_EN
  logic [$clog2(N_SPIKES+1)-1:0] spike_count_o;
`endif
  bit lb = 1, mon = 0, stall = 0;
  int rdy_mode = 0, ph = 0, idle_cnt = 0, tx_k = 0, rx_k = 0, n_done = 0;
  int n_checks = 0, n_fail = 0;
  logic [TOT-1:0] cur_frame = '0;
  logic [BEAT_W:0] hold = '0;
  logic [BEAT_W-1:0] q[$];
  logic [BEAT_W-1:0] popped;
  logic [3:0] pat = 4'b1101;
  always #5 clk = ~clk;
  assign rx_valid_i = lb ? tx_valid_o && tx_ready_i : rx_valid_r;
  assign rx_data_i = lb ? tx_data_o : rx_data_r;
  spiker_stream_adapter #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES), .BEAT_W(BEAT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .spikes_i(spikes_i),
    .busy_o(busy_o), .done_o(done_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_data_o(tx_data_o), .tx_last_o(tx_last_o), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .rx_data_i(rx_data_i), .result_o(result_o), .result_valid_o(result_valid_o)
`ifdef SPIKER_STREAM_POPCNT_EN
    , .spike_count_o(spike_count_o)
`endif
  );
  task automatic check(input string tag, input logic [TOT-1:0] got, input logic [TOT-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [BEAT_W-1:0] exp_beat(input logic [TOT-1:0] s, input int k);
    logic [BEAT_W-1:0] r = '0;
    for (int b = 0; b < BEAT_W; b++) if (k * BEAT_W + b < N_SPIKES) r[b] = s[k*BEAT_W+b];
    return r;
  endfunction
  function automatic logic [TOT-1:0] exp_result(input logic [TOT-1:0] s);
    logic [TOT-1:0] r = '0;
    for (int i = 0; i < N_SPIKES; i++) r[i] = s[i];
    return r;
  endfunction
  function automatic int popc(input logic [TOT-1:0] s);
    int c = 0;
    for (int i = 0; i < N_SPIKES; i++) c += int'(s[i]);
    return c;
  endfunction
  function automatic logic [TOT-1:0] rnd_frame();
    logic [TOT-1:0] r;
    for (int w = 0; w < N_WORDS; w++) r[w*WIDTH +: WIDTH] = $urandom;
    return r;
  endfunction
  // core model: ready pattern plus a delayed result queue
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready_i = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? pat[ph] : 1'($urandom_range(1));
    ph = (ph + 1) % 4;
    if (tx_k >= N_BEATS) idle_cnt++;
    rx_valid_r = tx_k >= N_BEATS && idle_cnt > 10 && q.size() > 0;
    rx_data_r = q.size() > 0 ? q[0] : '0;
  end
  // stream monitor: expected beat content, stall stability, handshake bookkeeping
  always @(negedge clk) if (mon) begin
    if (stall) check("tx_hold", {tx_valid_o, tx_data_o}, hold);
    if (tx_valid_o) begin
      check("tx_data", tx_data_o, exp_beat(cur_frame, tx_k));
      check("tx_last", tx_last_o, tx_k == N_BEATS - 1);
    end
    stall = tx_valid_o && !tx_ready_i;
    hold = {tx_valid_o, tx_data_o};
    if (tx_valid_o && tx_ready_i) begin
      if (!lb) q.push_back(tx_data_o);
      tx_k++;
    end
    if (rx_valid_i && rx_ready_o) begin
      rx_k++;
      if (!lb && q.size() > 0) popped = q.pop_front();
    end
    if (done_o) n_done++;
  end
  task automatic run_frame(input logic [TOT-1:0] s, input bit lbm, input int rm, input int poke, input bit abort);
    int n = 0;
    bit got = 0;
    @(negedge clk);
    lb = lbm; rdy_mode = rm; cur_frame = s; tx_k = 0; rx_k = 0; idle_cnt = 0; stall = 0; n_done = 0;
    q.delete();
    @(posedge clk);
    #1 spikes_i = s; start_i = 1;
    @(posedge clk);
    #1 start_i = 0; mon = 1;
    while (!got && n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 1) check("first_valid", tx_valid_o, 1'b1);
      start_i = n == poke;
      if (n == poke) spikes_i = ~s;
      if (abort && tx_k >= 20) begin
        rst_i = 1; mon = 0;
        @(negedge clk);
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_tx_valid", tx_valid_o, 0);
        check("abort_rx_ready", rx_ready_o, 0);
        check("abort_tx_last", tx_last_o, 0);
        check("abort_result_valid", result_valid_o, 0);
        check("abort_result", result_o, 0);
        rst_i = 0;
        return;
      end
      if (done_o) got = 1;
      else check("busy_in_frame", busy_o, 1'b1);
    end
    check("done_seen", got, 1'b1);
    if (lbm && rm == 0) check("done_latency", n, N_BEATS + 1);
    check("done_busy", busy_o, 0);
    check("result_valid_at_done", result_valid_o, 1'b1);
    check("result_at_done", result_o, exp_result(s));
`ifdef SPIKER_STREAM_POPCNT_EN
    check("spike_count", spike_count_o, popc(s));
`endif
    @(negedge clk);
    mon = 0;
    check("done_pulse", done_o, 0);
    check("done_count", n_done, 1);
    check("tx_beats", tx_k, N_BEATS);
    check("rx_beats", rx_k, N_BEATS);
    check("result_valid_hold", result_valid_o, 1'b1);
    check("result_hold", result_o, exp_result(s));
  endtask
  initial begin
    logic [TOT-1:0] alt;
    for (int w = 0; w < N_WORDS; w++) alt[w*WIDTH +: WIDTH] = 32'hAAAAAAAA;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    @(negedge clk);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_tx_valid", tx_valid_o, 0);
    check("reset_rx_ready", rx_ready_o, 0);
    check("reset_tx_last", tx_last_o, 0);
    check("reset_result_valid", result_valid_o, 0);
    check("reset_result", result_o, 0);
    run_frame(alt, 1, 0, 0, 0);
    run_frame(rnd_frame(), 1, 1, 0, 0);
    run_frame(rnd_frame(), 0, 0, 0, 0);
    run_frame(rnd_frame(), 0, 2, 0, 0);
    run_frame(rnd_frame(), 1, 0, 5, 0);
    run_frame(rnd_frame(), 1, 0, 0, 1);
    run_frame(rnd_frame(), 1, 2, 0, 0);
    run_frame({TOT{1'b1}}, 1, 0, 0, 0);
    run_frame('0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) run_frame(rnd_frame(), 1, 2, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
